add8u_err_scanner: RTL
======================

ADD8U_ERR_SCANNER -- requirements
Module: add8u_err_scanner

Interface
REQ-001 SHALL have parameter W, default 8: operand width of the characterized approximate adder.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a full sweep; sampled only in IDLE.
REQ-005 SHALL have port busy, output, 1: high from start acceptance until DONE.
REQ-006 SHALL have port done, output, 1: one-cycle pulse when the sweep completes.
REQ-007 SHALL have ports op_a and op_b, output, W each: operands driven to the external combinational approximate adder.
REQ-008 SHALL have port approx_sum, input, W+1: adder result for the current op_a/op_b.
REQ-009 SHALL have ports lut_valid (output, 1), lut_ready (input, 1), lut_addr (output, 2W, equal to {op_a,op_b}) and lut_data (output, W+1, captured approx_sum): the LUT entry stream.
REQ-010 SHALL have ports sum_abs_err (output, 3W+1), max_err (output, W+1) and err_count (output, 2W+1): error statistics.

Function
REQ-011 SHALL implement FSM IDLE -> DRIVE -> CAPTURE -> EMIT -> (DRIVE | DONE) -> IDLE.
REQ-012 In IDLE, start=1 SHALL clear all statistics and the index, set busy, and move to DRIVE; start is ignored in every other state.
REQ-013 In DRIVE, op_a SHALL equal index[2W-1:W] and op_b SHALL equal index[W-1:0]; the index starts at 0.
REQ-014 In CAPTURE, approx_sum SHALL be registered into lut_data, and err = |approx_sum - (op_a+op_b)| SHALL be computed at W+2-bit precision.
REQ-015 In the same CAPTURE cycle, the block SHALL add err to sum_abs_err, set max_err = max(max_err, err), and increment err_count if err != 0.
REQ-016 In EMIT, lut_valid SHALL be 1, and a beat is transferred in any cycle with lut_valid && lut_ready, including the first EMIT cycle.
REQ-017 While lut_ready=0, lut_valid, lut_addr, lut_data, op_a and op_b SHALL hold stable.
REQ-018 On transfer, if index = 2^(2W)-1, the FSM SHALL go to DONE; otherwise the index increments and the FSM goes to DRIVE.
REQ-019 Per-pair cost SHALL be exactly 3 cycles with lut_ready held high, so a full sweep at W=8 takes 196608 cycles followed by 1 DONE cycle.
REQ-020 DONE SHALL assert done for one cycle, clear busy, and return to IDLE; statistics SHALL hold until the next accepted start.
REQ-021 Statistics SHALL never wrap: their widths cover the worst case of every pair at maximum error.

Reset
REQ-022 When rst=1, the block SHALL enter IDLE, clear busy, done, lut_valid, op_a, op_b, lut_addr, lut_data, index and all statistics to 0 on the next edge, aborting any sweep in progress.
REQ-023 rst SHALL take priority over start and lut_ready.

Configuration
REQ-024 With macro ADD8U_SCAN_MSE_EN defined, the block SHALL add output sum_sq_err (4W+2 bits), which accumulates err*err in CAPTURE and is cleared like the other statistics.
REQ-025 Without ADD8U_SCAN_MSE_EN, the port and the multiplier SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package add8u_scan_pkg SHALL hold the FSM state enum and the width localparam functions (addr 2W, sum W+1, accumulator 3W+1, count 2W+1, square 4W+2).
REQ-027 Sub-module add8u_err_accum SHALL hold the error computation and the statistics registers (clear/enable inputs); the FSM and the stream logic SHALL stay in the top level.

Verification
REQ-028 Exact adder (approx_sum = op_a+op_b), lut_ready=1, W=8 -> 65536 beats, lut_data = a+b, sum_abs_err=0, max_err=0, err_count=0, done pulse at cycle 196609 after start.
REQ-029 approx_sum tied to 0 -> max_err=510, err_count=65535, sum_abs_err=16711680, and with MSE_EN sum_sq_err=4977295360.
REQ-030 Adder with an OR-approximated low bit (approx_sum = exact except bit0 = a0|b0, no carry from bit 0); pair a=1,b=1 -> lut_data=1 at lut_addr 0x0101, err=1, and that pair is counted in err_count.
REQ-031 lut_ready low for 5 cycles at index 3 -> lut_valid stays 1, lut_addr=0x0003 and lut_data stay stable, op_a/op_b stay unchanged, and no beat is duplicated or dropped.
REQ-032 rst pulse at index 100, then start -> outputs are 0 the cycle after reset, start during busy is ignored, and the new sweep re-emits from lut_addr 0 with statistics equal to a clean run.

Source files
------------

// File: rtl/add8u_scan_pkg.sv
// rtl/add8u_scan_pkg.sv - scanner FSM states and derived width helpers
package add8u_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } scan_state_e;

  function automatic int addr_w(input int w);
    return 2 * w;
  endfunction

  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  function automatic int err_w(input int w);
    return w + 2;
  endfunction

  function automatic int acc_w(input int w);
    return 3 * w + 1;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sq_w(input int w);
    return 4 * w + 2;
  endfunction

endpackage

// File: rtl/add8u_err_scanner_if.sv
// rtl/add8u_err_scanner_if.sv - LUT entry stream (addr = {op_a,op_b}, data = captured sum)
interface add8u_err_scanner_if
  import add8u_scan_pkg::*;
#(
  parameter int W = 8
);

  logic                  lut_valid;
  logic                  lut_ready;
  logic [addr_w(W)-1:0]  lut_addr;
  logic [sum_w(W)-1:0]   lut_data;

  modport master (output lut_valid, output lut_addr, output lut_data, input lut_ready);
  modport slave  (input lut_valid, input lut_addr, input lut_data, output lut_ready);

endinterface

// File: rtl/add8u_err_accum.sv
// rtl/add8u_err_accum.sv - absolute error of one adder result and running statistics
// Squared-error accumulator present only with ADD8U_SCAN_MSE_EN.
module add8u_err_accum
  import add8u_scan_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [W-1:0]         op_a_i,
  input  logic [W-1:0]         op_b_i,
  input  logic [sum_w(W)-1:0]  approx_sum_i,
  output logic [acc_w(W)-1:0]  sum_abs_err_o,
  output logic [sum_w(W)-1:0]  max_err_o,
  output logic [cnt_w(W)-1:0]  err_count_o
`ifdef ADD8U_SCAN_MSE_EN
  ,
  output logic [sq_w(W)-1:0]   sum_sq_err_o
`endif
);

  localparam int SW = sum_w(W);
  localparam int EW = err_w(W);
  localparam int AW = acc_w(W);
  localparam int CW = cnt_w(W);

  logic [EW-1:0] exact, approx, err;
  logic [SW-1:0] err_lo;
  logic [AW-1:0] sum_q, sum_d;
  logic [SW-1:0] max_q, max_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Top bit of err is always zero: |diff| never exceeds 2^(W+1)-1.
  always_comb begin
    exact  = {2'b00, op_a_i} + {2'b00, op_b_i};
    approx = {1'b0, approx_sum_i};
    err    = (approx >= exact) ? (approx - exact) : (exact - approx);
    err_lo = err[SW-1:0];
    sum_d  = sum_q + AW'(err_lo);
    max_d  = (err_lo > max_q) ? err_lo : max_q;
    cnt_d  = cnt_q + ((err_lo != '0) ? CW'(1) : CW'(0));
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum_abs_err_o = sum_q;
  assign max_err_o     = max_q;
  assign err_count_o   = cnt_q;

`ifdef ADD8U_SCAN_MSE_EN
  localparam int QW = sq_w(W);
  logic [2*SW-1:0] err_sq;
  logic [QW-1:0]   sq_q, sq_d;

  always_comb begin
    err_sq = {{SW{1'b0}}, err_lo} * {{SW{1'b0}}, err_lo};
    sq_d   = sq_q + QW'(err_sq);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sq_q <= '0;
    end else if (en_i) begin
      sq_q <= sq_d;
    end
  end

  assign sum_sq_err_o = sq_q;
`endif

endmodule

// File: rtl/add8u_err_scanner.sv
// rtl/add8u_err_scanner.sv - exhaustive error sweep of an external approximate W-bit adder
// Optional sum_sq_err output enabled by ADD8U_SCAN_MSE_EN.
module add8u_err_scanner
  import add8u_scan_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         op_a,
  output logic [W-1:0]         op_b,
  input  logic [sum_w(W)-1:0]  approx_sum,
  add8u_err_scanner_if.master  lut,
  output logic [acc_w(W)-1:0]  sum_abs_err,
  output logic [sum_w(W)-1:0]  max_err,
  output logic [cnt_w(W)-1:0]  err_count
`ifdef ADD8U_SCAN_MSE_EN
  ,
  output logic [sq_w(W)-1:0]   sum_sq_err
`endif
);

  localparam int AW = addr_w(W);
  localparam int SW = sum_w(W);

  scan_state_e   state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [SW-1:0] lut_data_q, lut_data_d;
  logic          acc_clr, acc_en;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    lut_data_d = lut_data_q;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          index_d = '0;
          acc_clr = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        lut_data_d = approx_sum;
        acc_en     = 1'b1;
        state_d    = ST_EMIT;
      end
      // index only moves on a transfer, so operands and addr hold through backpressure
      ST_EMIT: begin
        if (lut.lut_ready) begin
          if (index_q == '1) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + AW'(1);
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      lut_data_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      lut_data_q <= lut_data_d;
    end
  end

  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign op_a          = index_q[AW-1:W];
  assign op_b          = index_q[W-1:0];
  assign lut.lut_valid = (state_q == ST_EMIT);
  assign lut.lut_addr  = index_q;
  assign lut.lut_data  = lut_data_q;

  add8u_err_accum #(.W(W)) u_accum (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (acc_clr),
    .en_i          (acc_en),
    .op_a_i        (op_a),
    .op_b_i        (op_b),
    .approx_sum_i  (approx_sum),
    .sum_abs_err_o (sum_abs_err),
    .max_err_o     (max_err),
    .err_count_o   (err_count)
`ifdef ADD8U_SCAN_MSE_EN
    ,
    .sum_sq_err_o  (sum_sq_err)
`endif
  );

endmodule
